// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_pkg
// Description : Shared state encoding and default widths for mac_onehot_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

    localparam int IDX_W_DEF  = 4;
    localparam int STEP_W_DEF = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mac_onehot_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_onehot_seq_if
// Description : Descriptor and beat-stream signals of the one-hot sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_onehot_seq_if
    import mac_seq_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int STEP_W = STEP_W_DEF,
    parameter int N      = 2**IDX_W
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [IDX_W-1:0]  cfg_base;
    logic [IDX_W:0]    cfg_len;
    logic [STEP_W-1:0] cfg_step;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic [N-1:0]      out_onehot;
    logic              out_last;
    logic              done;

    // master issues descriptors and consumes beats; slave is the sequencer
    modport master (
        output cfg_valid, cfg_base, cfg_len, cfg_step, out_ready,
        input  cfg_ready, out_valid, out_idx, out_onehot, out_last, done
    );

    modport slave (
        input  cfg_valid, cfg_base, cfg_len, cfg_step, out_ready,
        output cfg_ready, out_valid, out_idx, out_onehot, out_last, done
    );

endinterface
`default_nettype wire

// File: rtl/mac_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : mac_onehot_dec
// Description : Combinational index to one-hot decoder with enable.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_onehot_dec #(
    parameter int IDX_W = 4,
    parameter int N     = 2**IDX_W
) (
    input  wire logic [IDX_W-1:0] i_idx,
    input  wire logic             i_en,
    output logic      [N-1:0]     o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_onehot_seq.sv
`default_nettype none
// ============================================================================
// Module      : mac_onehot_seq
// Description : Burst index sequencer emitting registered index/one-hot beats.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_onehot_seq
    import mac_seq_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int N      = 2**IDX_W,
    parameter int STEP_W = STEP_W_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mac_onehot_seq_if.slave  bus
);

    localparam logic [IDX_W:0] c_len_one = (IDX_W+1)'(1);

    generate
        if (N != 2**IDX_W || IDX_W < 1 || IDX_W > 12) begin : g_param_check
            $error("mac_onehot_seq: IDX_W must be 1..12 and N must equal 2**IDX_W");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [IDX_W:0]    len_q, len_d;
    logic [IDX_W:0]    cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [N-1:0]      onehot_q, onehot_d;
    logic [N-1:0]      w_onehot;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = step_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    if (bus.cfg_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        idx_d   = bus.cfg_base;
                        step_d  = bus.cfg_step;
                        len_d   = bus.cfg_len;
                        cnt_d   = c_len_one;
                        valid_d = 1'b1;
                        last_d  = (bus.cfg_len == c_len_one);
                    end
                end
            end
            RUN: begin
                if (bus.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // truncating to IDX_W bits gives the silent modulo-N wrap
                        idx_d  = idx_q + IDX_W'(step_q);
                        cnt_d  = cnt_q + c_len_one;
                        last_d = ((cnt_q + c_len_one) == len_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
        onehot_d = w_onehot;
    end

    mac_onehot_dec #(
        .IDX_W (IDX_W),
        .N     (N)
    ) u_dec (
        .i_idx    (idx_d),
        .i_en     (valid_d),
        .o_onehot (w_onehot)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            step_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            step_q   <= step_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
            onehot_q <= onehot_d;
        end
    end

    assign bus.cfg_ready  = (state_q == IDLE);
    assign bus.out_valid  = valid_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = onehot_q;
    assign bus.out_last   = last_q;
    assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: doc/mac_onehot_seq.md
MAC_ONEHOT_SEQ -- requirements
Module: mac_onehot_seq

Interface
REQ-001 Parameter IDX_W, default 4, index width; SHALL be legal for 1..12.
REQ-002 Parameter N, default 2**IDX_W, one-hot output width; SHALL always equal 2**IDX_W.
REQ-003 Parameter STEP_W, default 2, width of the per-burst index increment.
REQ-004 Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  in  1  asynchronous, active-low reset.
REQ-006 Port cfg_valid  in  1  burst descriptor valid.
REQ-007 Port cfg_ready  out  1  descriptor accepted when high with cfg_valid.
REQ-008 Port cfg_base  in  IDX_W  first index of the burst.
REQ-009 Port cfg_len  in  IDX_W+1  beat count, 0..N.
REQ-010 Port cfg_step  in  STEP_W  index increment per beat; 0 repeats the same index.
REQ-011 Port out_valid  out  1  output beat valid.
REQ-012 Port out_ready  in  1  consumer accepts the beat when high with out_valid.
REQ-013 Port out_idx  out  IDX_W  current index.
REQ-014 Port out_onehot  out  N  decode of out_idx: bit out_idx is 1, all others 0.
REQ-015 Port out_last  out  1  final beat of the burst.
REQ-016 Port done  out  1  one-cycle pulse at burst completion.

Function
REQ-017 FSM SHALL have two states, IDLE and RUN; reset state SHALL be IDLE.
REQ-018 cfg_ready SHALL be 1 only in IDLE.
REQ-019 IDLE with cfg_valid=1 and cfg_len>0: SHALL latch base, len and step, go to RUN, and assert out_valid with out_idx=cfg_base on the next cycle (latency 1).
REQ-020 IDLE with cfg_valid=1 and cfg_len=0: SHALL stay in IDLE, emit no beat, and pulse done on the next cycle.
REQ-021 RUN: out_idx, out_onehot and out_last SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-022 On a handshake that is not the last beat, the next beat SHALL appear the following cycle with out_idx = (out_idx + step) mod N; wrap-around SHALL be silent.
REQ-023 out_last SHALL be 1 exactly on beat number len, counted 1-based.
REQ-024 On the handshake of the last beat: out_valid SHALL drop the next cycle, done SHALL pulse the next cycle, and the FSM SHALL return to IDLE.
REQ-025 A new descriptor SHALL be accepted no earlier than the cycle done is high; there SHALL be exactly one idle cycle between bursts.
REQ-026 The step SHALL be zero-extended to IDX_W before the modulo-N add; the beat counter SHALL be IDX_W+1 bits so that len=N is legal.
REQ-027 out_onehot SHALL be all-zero whenever out_valid=0.
REQ-028 cfg_* inputs SHALL be ignored in RUN and SHALL NOT corrupt the latched descriptor.

Reset
REQ-029 Asserting rst low SHALL immediately force IDLE, out_valid=0, out_idx=0, out_onehot=0, out_last=0, done=0 and cfg_ready=1 (cfg_ready=1 once rst is released).
REQ-030 A reset in the middle of a burst SHALL abandon the burst with no done pulse; the first descriptor after reset release SHALL behave as after power-up.

Structure
REQ-031 Shared package mac_seq_pkg SHALL hold the state enum (IDLE, RUN) and the default values of IDX_W and STEP_W.
REQ-032 One sub-module mac_onehot_dec SHALL hold the combinational IDX_W-to-N decoder; all sequential logic SHALL stay in mac_onehot_seq.

Verification
REQ-033 IDX_W=4: base=14, len=4, step=1, out_ready=1 -> out_idx 14,15,0,1 on consecutive cycles; out_onehot 0x4000,0x8000,0x0001,0x0002; out_last on idx 1; done one cycle later.
REQ-034 base=3, len=3, step=2, out_ready low for 3 cycles on beat 2 -> idx 5 held stable for 4 cycles, then idx 7 with out_last=1.
REQ-035 cfg_len=0 -> no out_valid; done pulses 1 cycle after acceptance; cfg_ready stays 1.
REQ-036 len=16, step=0, base=9 -> 16 beats all with idx 9; out_last only on beat 16.
REQ-037 rst low asserted on beat 2 of a len=8 burst -> outputs immediately zero, no done; a new burst base=0, len=1 -> single beat idx 0 with out_last=1.
REQ-038 IDX_W=1 and IDX_W=12 elaboration -> N=2 and N=4096; a len=N, step=1 burst covers every index exactly once.
